// File: rtl/mac_pkg.sv
// Shared types and helpers for the dot-product MAC engine.
// Optional build macro: MAC_SAT_EN (saturating accumulation with sticky overflow).
package mac_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_ACC_W  = 40;
    localparam int DEF_LEN_W  = 8;

    // Widest accumulator the helper functions can serve.
    localparam int MAX_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Replicate bit (from_w-1) of v into every higher bit.
    function automatic logic [MAX_W-1:0] sign_ext(input logic [MAX_W-1:0] v, input int from_w);
        logic [MAX_W-1:0] r;
        for (int i = 0; i < MAX_W; i++) begin
            r[i] = (i < from_w) ? v[i] : v[from_w-1];
        end
        return r;
    endfunction

    // Signed limit of a w-bit value: most negative when neg=1, most positive otherwise.
    function automatic logic [MAX_W-1:0] sat_limit(input logic neg, input int w);
        logic [MAX_W-1:0] r;
        for (int i = 0; i < MAX_W; i++) begin
            r[i] = (i < w - 1) ? ~neg : neg;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_dot_engine_ram.sv
// Operand store: one write port and two synchronous read ports.
// A read of an address written in the same cycle returns the old word.
module mac_dp_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Write and both reads share one edge; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_a <= mem[rd_addr_a];
        rd_data_b <= mem[rd_addr_b];
    end

endmodule

// File: rtl/mac_dot_engine.sv
// Signed dot-product engine: read -> multiply -> accumulate pipeline over an
// internal dual-port operand memory, one result per command.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// res_data/res_ovf hold steady while res_valid=1 and res_ready=0.
// Optional build macro: MAC_SAT_EN (saturate accumulator, sticky res_ovf).
module mac_dot_engine
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base_a,
    input  logic [ADDR_W-1:0] cmd_base_b,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_acc,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_ovf,
    output logic              busy
);

    state_t state, state_nxt;

    logic [ADDR_W-1:0]   base_a, base_b;
    logic [LEN_W-1:0]    len, idx;
    logic [DATA_W-1:0]   q_a, q_b;
    logic                v1, v2;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    acc, prev_acc, prod_ext, acc_sum;
    logic                accept, issue, last_issue, enter_done;

    assign accept     = (state == ST_IDLE) && cmd_valid;
    assign issue      = (state == ST_RUN);
    assign last_issue = issue && (idx == len - LEN_W'(1));
    assign enter_done = (state == ST_DRAIN) && !v1 && !v2;

    mac_dp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk       (clk),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (base_a + ADDR_W'(idx)),
        .rd_addr_b (base_b + ADDR_W'(idx)),
        .rd_data_a (q_a),
        .rd_data_b (q_b)
    );

    assign prod_ext = ACC_W'(sign_ext(MAX_W'(prod), 2*DATA_W));

`ifdef MAC_SAT_EN
    logic [ACC_W:0] sum_ext;
    logic           add_ovf;
    logic           ovf;

    assign sum_ext = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
    assign add_ovf = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    assign acc_sum = add_ovf ? ACC_W'(sat_limit(sum_ext[ACC_W], ACC_W)) : sum_ext[ACC_W-1:0];
    assign res_ovf = ovf;

    // Sticky overflow: cleared when a command is taken, set by any clipped add.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (accept) begin
            ovf <= 1'b0;
        end else if (v2 && add_ovf) begin
            ovf <= 1'b1;
        end
    end
`else
    assign acc_sum = acc + prod_ext;
    assign res_ovf = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and status outputs. A zero-length command passes through
    // DRAIN (pipeline already empty) so its result appears one edge after accept.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_nxt = (cmd_len == '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_issue) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!v1 && !v2) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Command latch, read index, multiply and accumulate stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_a   <= '0;
            base_b   <= '0;
            len      <= '0;
            idx      <= '0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            prod     <= '0;
            acc      <= '0;
            prev_acc <= '0;
        end else begin
            v1 <= issue;
            v2 <= v1;
            if (v1) begin
                prod <= {{DATA_W{q_a[DATA_W-1]}}, q_a} * {{DATA_W{q_b[DATA_W-1]}}, q_b};
            end
            if (accept) begin
                base_a <= cmd_base_a;
                base_b <= cmd_base_b;
                len    <= cmd_len;
                idx    <= '0;
                acc    <= cmd_acc ? prev_acc : '0;
            end else begin
                if (issue) begin
                    idx <= idx + LEN_W'(1);
                end
                if (v2) begin
                    acc <= acc_sum;
                end
            end
            if (enter_done) begin
                prev_acc <= acc;
            end
        end
    end

    assign res_data = prev_acc;

endmodule
